// File: rtl/pipe_hazard_unit_pkg.sv
// Shared datapath definitions: default widths and the hazard slot record.
// Slot addresses are stored zero-extended to RSIZE_MAX bits.
package pipe_hazard_unit_pkg;

  localparam int DSIZE_DEF = 16;
  localparam int RSIZE_DEF = 4;
  localparam int RSIZE_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [RSIZE_MAX-1:0] waddr;
    logic                 load;
  } slot_t;

  function automatic slot_t mk_slot(
    input logic                 v,
    input logic [RSIZE_MAX-1:0] a,
    input logic                 l
  );
    slot_t s;
    s.valid = v;
    s.waddr = a;
    s.load  = l;
    return s;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Per-operand priority compare against the in-flight slots.
// Forwarding paths exist only when HAZARD_FORWARD_EN is defined.
module hazard_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int DSIZE      = DSIZE_DEF,
  parameter int RSIZE      = RSIZE_DEF,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  localparam int SW        = $clog2(DEPTH+1)
) (
  input  logic                   ren,
  input  logic [RSIZE-1:0]       raddr,
  input  slot_t [DEPTH-1:0]      slots,
  input  logic [DEPTH*DSIZE-1:0] stage_data,
  output logic                   stall,
  output logic [SW-1:0]          sel,
  output logic [DSIZE-1:0]       data
);

  logic [RSIZE_MAX-1:0] addr;
  logic                 hit;
  logic                 hit_load;
  logic [SW-1:0]        hit_k;
  logic [DSIZE-1:0]     hit_data;

  assign addr = RSIZE_MAX'(raddr);

  // Walk oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_k    = '0;
    hit_data = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (ren && slots[k-1].valid &&
          slots[k-1].waddr == addr) begin
        hit      = 1'b1;
        hit_load = slots[k-1].load;
        hit_k    = SW'(k);
        hit_data = stage_data[(k-1)*DSIZE +: DSIZE];
      end
    end
  end

`ifdef HAZARD_FORWARD_EN
  assign stall = hit && hit_load &&
                 (hit_k < SW'(LOAD_READY));
  assign sel   = (hit && !stall) ? hit_k : '0;
  assign data  = (hit && !stall) ? hit_data : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{hit_load, hit_k, hit_data,
                        (LOAD_READY > 0)};
  assign stall = hit;
  assign sel   = '0;
  assign data  = '0;
`endif

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use hazard detection and operand forwarding for the pipeline.
// Define HAZARD_FORWARD_EN to enable forwarding; otherwise any match stalls.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int DSIZE      = DSIZE_DEF,
  parameter int RSIZE      = RSIZE_DEF,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  localparam int SW        = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic                   iss_wen,
  input  logic [RSIZE-1:0]       iss_waddr,
  input  logic                   iss_load,
  input  logic                   ren1,
  input  logic                   ren2,
  input  logic [RSIZE-1:0]       raddr1,
  input  logic [RSIZE-1:0]       raddr2,
  input  logic [DEPTH*DSIZE-1:0] stage_data,
  input  logic                   flush,
  output logic                   stall,
  output logic [SW-1:0]          fwd_sel1,
  output logic [SW-1:0]          fwd_sel2,
  output logic [DSIZE-1:0]       fwd_data1,
  output logic [DSIZE-1:0]       fwd_data2,
  output logic [15:0]            stall_cnt
);

  slot_t [DEPTH-1:0] slots;
  logic              stall1;
  logic              stall2;

  hazard_match #(
    .DSIZE(DSIZE), .RSIZE(RSIZE),
    .DEPTH(DEPTH), .LOAD_READY(LOAD_READY)
  ) u_match1 (
    .ren(ren1), .raddr(raddr1),
    .slots(slots), .stage_data(stage_data),
    .stall(stall1), .sel(fwd_sel1), .data(fwd_data1)
  );

  hazard_match #(
    .DSIZE(DSIZE), .RSIZE(RSIZE),
    .DEPTH(DEPTH), .LOAD_READY(LOAD_READY)
  ) u_match2 (
    .ren(ren2), .raddr(raddr2),
    .slots(slots), .stage_data(stage_data),
    .stall(stall2), .sel(fwd_sel2), .data(fwd_data2)
  );

  assign stall = (stall1 | stall2) & iss_valid & ~flush;

  // A flush kills both the decoded op and the one leaving slot 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots     <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall || flush)
        slots[0] <= '0;
      else
        slots[0] <= mk_slot(iss_valid & iss_wen,
                            RSIZE_MAX'(iss_waddr),
                            iss_load);
      for (int k = 1; k < DEPTH; k++)
        slots[k] <= slots[k-1];
      if (flush)
        slots[1] <= '0;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit against an age-list model.
// Works with or without HAZARD_FORWARD_EN defined.
module tb_pipe_hazard_unit;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int DEPTH = 3;
  localparam int LR = 3;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, iss_valid, iss_wen, iss_load;
  logic ren1, ren2, flush;
  logic [RW-1:0] iss_waddr, raddr1, raddr2;
  logic [DEPTH*DW-1:0] stage_data;
  logic stall;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [15:0] stall_cnt;

  pipe_hazard_unit #(
    .DSIZE(DW), .RSIZE(RW),
    .DEPTH(DEPTH), .LOAD_READY(LR)
  ) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_wen(iss_wen),
    .iss_waddr(iss_waddr), .iss_load(iss_load),
    .ren1(ren1), .ren2(ren2),
    .raddr1(raddr1), .raddr2(raddr2),
    .stage_data(stage_data), .flush(flush),
    .stall(stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // In-flight writers tracked by age (1 = one edge after issue).
  typedef struct {
    int age;
    int addr;
    bit load;
  } wr_t;

  typedef struct {
    bit          st;
    int          s1;
    logic [15:0] d1;
    int          s2;
    logic [15:0] d2;
    int          cnt;
  } exp_t;

  wr_t  live[$];
  exp_t sbq[$];
  int   mcnt = 0;
  bit   known = 1'b0;
  int   nchk = 0;
  int   nfail = 0;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endfunction

  function automatic void op_eval(
    input bit ren, input int addr,
    input logic [DEPTH*DW-1:0] sd,
    output bit st, output int sel, output logic [15:0] d
  );
    int best = 0;
    bit bl = 1'b0;
    st = 1'b0;
    sel = 0;
    d = '0;
    if (ren)
      foreach (live[i])
        if (live[i].addr == addr &&
            (best == 0 || live[i].age < best)) begin
          best = live[i].age;
          bl = live[i].load;
        end
    if (best != 0) begin
      if (!FWD || (bl && best < LR)) st = 1'b1;
      else begin
        sel = best;
        d = sd[(best-1)*DW +: DW];
      end
    end
  endfunction

  function automatic void model_edge(
    bit r, bit iv, bit iw, int wa, bit ld, bit fl, bit st
  );
    wr_t nl[$];
    if (r) begin
      live.delete();
      mcnt = 0;
      return;
    end
    if (st && mcnt != 65535) mcnt++;
    foreach (live[i]) begin
      wr_t w = live[i];
      w.age++;
      if (w.age <= DEPTH && !(fl && w.age == 2))
        nl.push_back(w);
    end
    live = nl;
    if (!st && !fl && iv && iw)
      live.push_back('{age: 1, addr: wa, load: ld});
  endfunction

  task automatic cyc(bit r, bit iv, bit iw, int wa,
                     bit ld, bit e1, int a1, bit e2,
                     int a2, bit fl);
    logic [DEPTH*DW-1:0] sd;
    bit s1, s2, st;
    int x1, x2;
    logic [15:0] d1, d2;
    sd = {16'($urandom), 32'($urandom)};
    rst = r; iss_valid = iv; iss_wen = iw;
    iss_waddr = RW'(wa); iss_load = ld;
    ren1 = e1; raddr1 = RW'(a1);
    ren2 = e2; raddr2 = RW'(a2);
    flush = fl; stage_data = sd;
    st = 1'b0;
    if (known) begin
      op_eval(e1, a1, sd, s1, x1, d1);
      op_eval(e2, a2, sd, s2, x2, d2);
      st = (s1 || s2) && iv && !fl;
      sbq.push_back('{st, x1, d1, x2, d2, mcnt});
    end
    @(posedge clk);
    model_edge(r, iv, iw, wa, ld, fl, st);
    if (r) known = 1'b1;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", 32'(stall), 32'(e.st));
        chk("fwd_sel1", 32'(fwd_sel1), e.s1);
        chk("fwd_data1", 32'(fwd_data1), 32'(e.d1));
        chk("fwd_sel2", 32'(fwd_sel2), e.s2);
        chk("fwd_data2", 32'(fwd_data2), 32'(e.d2));
        chk("stall_cnt", 32'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin : stim
    int c0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    idle();
    // ALU write r2 then read r2
    cyc(0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 2, 1, 2, 0);
    idle(); idle(); idle();
    // load r5 then load-use
    c0 = stall_cnt;
    cyc(0, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("load_use_stalls", 32'(stall_cnt) - c0,
        FWD ? 2 : 3);
    idle(); idle(); idle();
    // youngest wins
    cyc(0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 3, 1, 7, 0);
    idle(); idle(); idle();
    // load r4 flushed
    cyc(0, 1, 1, 4, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1, 4, 1, 4, 0);
    idle(); idle(); idle();
    // ALU r1 then read r1
    c0 = stall_cnt;
    cyc(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("alu_use_stalls", 32'(stall_cnt) - c0,
        FWD ? 0 : 3);
    // reset during load-use stall
    cyc(0, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 5, 1, 5, 0);
    cyc(1, 1, 0, 0, 0, 1, 5, 1, 5, 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_sel1", 32'(fwd_sel1), 0);
    chk("rst_sel2", 32'(fwd_sel2), 0);
    idle();
    repeat (1500) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 3) != 0),
          $urandom_range(0, 7),
          ($urandom_range(0, 2) == 0),
          $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 7),
          ($urandom_range(0, 9) == 0));
    end
    @(negedge clk);
    #1;
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
